pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MC_TIMEOUT, default 64, meaning max MC_WAIT cycles before forced release.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports jump_en_i input 1 and jump_addr_i input 32: taken branch/JAL/JALR resolved in EX, with target.
REQ-005 SHALL have ports ex_mem_rd_i input 1 (EX holds a load), ex_reg_wen_i input 1, ex_rd_addr_i input 5.
REQ-006 SHALL have ports id_rs1_addr_i input 5 and id_rs2_addr_i input 5: source registers of the decoded instruction.
REQ-007 SHALL have ports mc_start_i input 1 (multi-cycle op issued in EX) and mc_done_i input 1 (its result valid).
REQ-008 SHALL have outputs pc_hold_o 1, if_id_hold_o 1, id_ex_hold_o 1, id_ex_bubble_o 1, flush_o 1: pipeline register controls.
REQ-009 SHALL have outputs jump_en_o 1 and jump_addr_o 32 (PC redirect), state_o 2, stall_cnt_o 16, mc_timeout_o 1.

Function
REQ-010 SHALL implement FSM states RUN=0, REDIRECT=1, MC_WAIT=2; state_o reflects the current state.
REQ-011 RUN, jump_en_i=1: flush_o=1 same cycle (combinational), jump_addr_i latched, next state REDIRECT.
REQ-012 REDIRECT: jump_en_o=1, jump_addr_o=latched address, flush_o=1 for exactly this one cycle; next state RUN unconditionally; all other inputs ignored.
REQ-013 jump_en_o SHALL be 0 and jump_addr_o SHALL hold its last latched value in every state other than REDIRECT.
REQ-014 Load-use hazard = ex_mem_rd_i & ex_reg_wen_i & (ex_rd_addr_i!=0) & (ex_rd_addr_i==id_rs1_addr_i | ex_rd_addr_i==id_rs2_addr_i).
REQ-015 RUN with load-use and no jump: pc_hold_o=1, if_id_hold_o=1, id_ex_bubble_o=1 in the same cycle (combinational); state stays RUN.
REQ-016 RUN, mc_start_i=1 and no jump: next state MC_WAIT; wait counter cleared to 0.
REQ-017 MC_WAIT: pc_hold_o, if_id_hold_o, id_ex_hold_o =1 (no bubble, no flush); counter increments each cycle.
REQ-018 MC_WAIT, mc_done_i=1: all holds deassert same cycle (combinational); next state RUN.
REQ-019 MC_WAIT, counter==MC_TIMEOUT-1 and mc_done_i=0: holds deassert that cycle, mc_timeout_o set sticky (cleared only by reset), next state RUN.
REQ-020 jump_en_i and mc_start_i during MC_WAIT SHALL be ignored.
REQ-021 Priority in RUN: jump > mc_start > load-use; lower-priority requests in the same cycle are dropped (no hold, no bubble).
REQ-022 stall_cnt_o SHALL increment by 1 on every cycle with pc_hold_o=1 and saturate at 16'hFFFF.
REQ-023 Wait counter SHALL be wide enough for MC_TIMEOUT (clog2) and never wrap.

Reset
REQ-024 rst_n=0 SHALL immediately force state RUN, wait counter 0, jump_addr_o 0, stall_cnt_o 0, mc_timeout_o 0.
REQ-025 During reset all hold/bubble/flush/jump_en outputs SHALL be 0.
REQ-026 Reset asserted mid-REDIRECT or mid-MC_WAIT SHALL abort the operation with no redirect issued after release.
REQ-027 First rising edge after rst_n deasserts SHALL evaluate inputs in RUN.

Verification
REQ-028 RUN, jump_en_i=1, jump_addr_i=32'h0000_0100 for 1 cycle -> flush_o=1 cycles T,T+1; jump_en_o=1 and jump_addr_o=32'h100 only at T+1; state 0->1->0.
REQ-029 ex_mem_rd_i=1, ex_reg_wen_i=1, ex_rd_addr_i=5, id_rs2_addr_i=5 -> pc_hold_o=if_id_hold_o=id_ex_bubble_o=1 same cycle; with ex_rd_addr_i=0 -> all 0.
REQ-030 mc_start_i pulse, mc_done_i after 3 MC_WAIT cycles -> holds high 3 cycles, low on done cycle, stall_cnt_o=3, mc_timeout_o=0.
REQ-031 mc_start_i, mc_done_i never -> release after exactly 64 MC_WAIT cycles, mc_timeout_o=1 and stays 1 until rst_n=0.
REQ-032 jump_en_i, mc_start_i and load-use together in RUN -> only redirect sequence; no holds, state never 2.
REQ-033 rst_n=0 during MC_WAIT cycle 10 -> outputs 0 immediately, state_o=0, no redirect/holds after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/control unit: branch redirect, load-use bubble and
// multi-cycle-op stall with timeout, plus a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ex_mem_rd_i,
    input  logic        ex_reg_wen_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        mc_start_i,
    input  logic        mc_done_i,
    output logic        pc_hold_o,
    output logic        if_id_hold_o,
    output logic        id_ex_hold_o,
    output logic        id_ex_bubble_o,
    output logic        flush_o,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt_o,
    output logic        mc_timeout_o
);

    localparam int unsigned CW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MC_TIMEOUT - 1);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_REDIRECT = 2'd1;
    localparam logic [1:0] ST_MC_WAIT  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]   jump_addr_q, jump_addr_d;
    logic [15:0]   stall_cnt_q, stall_cnt_d;
    logic          mc_timeout_q, mc_timeout_d;

    logic load_use;
    logic pc_hold, if_id_hold, id_ex_hold, id_ex_bubble, flush, jump_en;

    assign load_use = ex_mem_rd_i && ex_reg_wen_i && (ex_rd_addr_i != 5'd0) &&
                      ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        jump_addr_d  = jump_addr_q;
        mc_timeout_d = mc_timeout_q;
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        flush        = 1'b0;
        jump_en      = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                // Jump beats mc_start beats load-use; losers are simply dropped.
                if (jump_en_i) begin
                    flush       = 1'b1;
                    jump_addr_d = jump_addr_i;
                    state_d     = ST_REDIRECT;
                end else if (mc_start_i) begin
                    wait_cnt_d = '0;
                    state_d    = ST_MC_WAIT;
                end else if (load_use) begin
                    pc_hold      = 1'b1;
                    if_id_hold   = 1'b1;
                    id_ex_bubble = 1'b1;
                end
            end
            ST_REDIRECT: begin
                flush   = 1'b1;
                jump_en = 1'b1;
                state_d = ST_RUN;
            end
            ST_MC_WAIT: begin
                if (mc_done_i) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    mc_timeout_d = 1'b1;
                    state_d      = ST_RUN;
                end else begin
                    pc_hold    = 1'b1;
                    if_id_hold = 1'b1;
                    id_ex_hold = 1'b1;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign stall_cnt_d = (pc_hold && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1
                                                                : stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) begin
            state_q      <= ST_RUN;
            wait_cnt_q   <= '0;
            jump_addr_q  <= '0;
            stall_cnt_q  <= '0;
            mc_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            jump_addr_q  <= jump_addr_d;
            stall_cnt_q  <= stall_cnt_d;
            mc_timeout_q <= mc_timeout_d;
        end
    end

    // Combinational controls are masked while rst_n is low so live inputs cannot leak through.
    assign pc_hold_o      = pc_hold      & rst_n;
    assign if_id_hold_o   = if_id_hold   & rst_n;
    assign id_ex_hold_o   = id_ex_hold   & rst_n;
    assign id_ex_bubble_o = id_ex_bubble & rst_n;
    assign flush_o        = flush        & rst_n;
    assign jump_en_o      = jump_en      & rst_n;
    assign jump_addr_o    = jump_addr_q;
    assign state_o        = state_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign mc_timeout_o   = mc_timeout_q;

endmodule
